muldiv_hilo_ctrl: RTL and testbench

//  Multi-cycle sequencer for MULT/MULTU/DIV/DIVU and MTHI/MTLO that owns the architectural HI/LO

---
 rtl/muldiv_hilo_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_muldiv_hilo_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_hilo_ctrl.sv
// Iterative multiply/divide sequencer that owns the HI/LO registers (MULT/MULTU/DIV/DIVU/MTHI/MTLO).
// Optional macro MD_DIVZERO_FLAG_EN adds a sticky div_zero output.
module muldiv_hilo_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             rd_req,
    input  logic             rd_sel,
    output logic [WIDTH-1:0] rd_data,
    output logic [WIDTH-1:0] outHI,
    output logic [WIDTH-1:0] outLO,
    output logic             busy,
    output logic             stall,
    output logic             done,
`ifdef MD_DIVZERO_FLAG_EN
    output logic             div_zero,
`endif
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_RUN  = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic                 is_div_q, is_div_d;
    logic                 is_signed_q, is_signed_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 neg_res_q, neg_res_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;
`ifdef MD_DIVZERO_FLAG_EN
    logic                 div_zero_q, div_zero_d;
`endif

    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_diff;
    logic [WIDTH-1:0]     div_rem;
    logic [2*WIDTH-1:0]   prod_fix;
    logic [WIDTH-1:0]     quo_fix, rem_fix;

    // prod_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        abs_a     = (is_signed_q && a_q[WIDTH-1]) ? -a_q : a_q;
        abs_b     = (is_signed_q && b_q[WIDTH-1]) ? -b_q : b_q;
        mul_sum   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
        div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd_q};
        div_diff  = div_shift[WIDTH-1:0] - opnd_q;
        div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
        prod_fix  = neg_res_q ? -prod_q : prod_q;
        quo_fix   = neg_res_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
        rem_fix   = neg_rem_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    end

    always_comb begin
        state_d     = state_q;
        is_div_d    = is_div_q;
        is_signed_d = is_signed_q;
        a_d         = a_q;
        b_d         = b_q;
        opnd_d      = opnd_q;
        prod_d      = prod_q;
        cnt_d       = cnt_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
`ifdef MD_DIVZERO_FLAG_EN
        div_zero_d  = div_zero_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start && !op[2]) begin
                    state_d     = S_PREP;
                    a_d         = A;
                    b_d         = B;
                    is_div_d    = op[1];
                    is_signed_d = op[0];
                end else if (start && op == 3'b100) begin
                    hi_d = A;
                end else if (start && op == 3'b101) begin
                    lo_d = A;
                end
`ifdef MD_DIVZERO_FLAG_EN
                if (start && op[2:1] != 2'b11) div_zero_d = 1'b0;
`endif
            end
            S_PREP: begin
                neg_res_d = is_signed_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
                neg_rem_d = is_signed_q & a_q[WIDTH-1];
                cnt_d     = '0;
                if (is_div_q) begin
                    prod_d = {{WIDTH{1'b0}}, abs_a};
                    opnd_d = abs_b;
                end else begin
                    prod_d = {{WIDTH{1'b0}}, abs_b};
                    opnd_d = abs_a;
                end
                state_d = S_RUN;
            end
            S_RUN: begin
                if (is_div_q) prod_d = {div_rem, prod_q[WIDTH-2:0], div_ge};
                else          prod_d = {mul_sum, prod_q[WIDTH-1:1]};
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    // A zero divisor reports the original signed dividend, not |A|.
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = quo_fix;
                        hi_d = rem_fix;
                    end
`ifdef MD_DIVZERO_FLAG_EN
                    div_zero_d = (b_q == '0);
`endif
                end else begin
                    hi_d = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d = prod_fix[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            is_div_q    <= 1'b0;
            is_signed_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            opnd_q      <= '0;
            prod_q      <= '0;
            cnt_q       <= '0;
            neg_res_q   <= 1'b0;
            neg_rem_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
`ifdef MD_DIVZERO_FLAG_EN
            div_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            is_div_q    <= is_div_d;
            is_signed_q <= is_signed_d;
            a_q         <= a_d;
            b_q         <= b_d;
            opnd_q      <= opnd_d;
            prod_q      <= prod_d;
            cnt_q       <= cnt_d;
            neg_res_q   <= neg_res_d;
            neg_rem_q   <= neg_rem_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
`ifdef MD_DIVZERO_FLAG_EN
            div_zero_q  <= div_zero_d;
`endif
        end
    end

    // Handshake: the issuer holds start (and rd_req) while stall=1; a start is taken only in IDLE.
    assign busy      = (state_q != S_IDLE);
    assign stall     = busy & (rd_req | start);
    assign done      = (state_q == S_DONE);
    assign outHI     = hi_q;
    assign outLO     = lo_q;
    assign rd_data   = rd_sel ? hi_q : lo_q;
    assign dbg_state = state_q;
`ifdef MD_DIVZERO_FLAG_EN
    assign div_zero  = div_zero_q;
`endif

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl: expected HI/LO and completion cycle are queued at issue
// and checked by a monitor whenever done is seen.
module tb_muldiv_hilo_ctrl;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] A, B;
    logic         rd_req, rd_sel;
    logic [W-1:0] rd_data, outHI, outLO;
    logic         busy, stall, done;
`ifdef MD_DIVZERO_FLAG_EN
    logic         div_zero;
`endif
    logic [2:0]   dbg_state;

    muldiv_hilo_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .op(op), .A(A), .B(B),
        .rd_req(rd_req), .rd_sel(rd_sel), .rd_data(rd_data), .outHI(outHI), .outLO(outLO),
        .busy(busy), .stall(stall), .done(done),
`ifdef MD_DIVZERO_FLAG_EN
        .div_zero(div_zero),
`endif
        .dbg_state(dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;
    logic [W-1:0] exp_hi_q[$];
    logic [W-1:0] exp_lo_q[$];
    int           exp_cyc_q[$];
    logic [W-1:0] cur_hi, cur_lo;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && busy; i++) step();
        check("idle_timeout", {31'b0, busy}, 32'd0);
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_hi_q.push_back(eh);
        exp_lo_q.push_back(el);
        exp_cyc_q.push_back(cyc + 35);
        start = 1'b1; op = o; A = a; B = b;
        step();
        start = 1'b0; op = 3'b111;
        wait_idle();
        cur_hi = eh;
        cur_lo = el;
    endtask

    // monitor / scoreboard
    logic [W-1:0] m_hi, m_lo;
    int           m_cyc;
    always @(negedge clk) begin
        if (reset_n && done) begin
            if (exp_hi_q.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                m_hi  = exp_hi_q.pop_front();
                m_lo  = exp_lo_q.pop_front();
                m_cyc = exp_cyc_q.pop_front();
                check("done_cycle", cyc, m_cyc);
                check("result_hi", outHI, m_hi);
                check("result_lo", outLO, m_lo);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

    logic [W-1:0] old_hi;

    initial begin
        reset_n = 1'b0; start = 1'b0; op = 3'b111; A = '0; B = '0;
        rd_req = 1'b1; rd_sel = 1'b1;
        cur_hi = '0; cur_lo = '0;
        step(); step(); step();
        @(negedge clk);
        check("rst_hi", outHI, 32'd0);
        check("rst_lo", outLO, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_stall", {31'b0, stall}, 32'd0);
        step();
        reset_n = 1'b1; rd_req = 1'b0;

        // MTHI / MTLO write immediately, no busy, no done
        start = 1'b1; op = 3'b100; A = 32'hDEADBEEF;
        @(negedge clk);
        check("mthi_busy", {31'b0, busy}, 32'd0);
        check("mthi_stall", {31'b0, stall}, 32'd0);
        step();
        op = 3'b101; A = 32'hCAFEF00D;
        @(negedge clk);
        check("mthi_hi", outHI, 32'hDEADBEEF);
        check("mthi_lo", outLO, 32'd0);
        step();
        start = 1'b1; op = 3'b110; A = 32'h11111111; B = 32'h2;
        @(negedge clk);
        check("mtlo_lo", outLO, 32'hCAFEF00D);
        check("mtlo_hi", outHI, 32'hDEADBEEF);
        step();
        op = 3'b111;
        @(negedge clk);
        step();
        start = 1'b0;
        @(negedge clk);
        check("nop_busy", {31'b0, busy}, 32'd0);
        check("nop_hi", outHI, 32'hDEADBEEF);
        check("nop_lo", outLO, 32'hCAFEF00D);
        step();

        // arithmetic vectors
        issue(3'b000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        issue(3'b001, 32'hFFFFFFF9, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFEB);
        issue(3'b001, 32'h80000000, 32'h00000002, 32'hFFFFFFFF, 32'h00000000);
        issue(3'b011, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
        issue(3'b010, 32'd100,      32'd7,        32'd2,        32'd14);
        issue(3'b010, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF);
        issue(3'b011, 32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'hFFFFFFFF);
        issue(3'b011, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
        issue(3'b000, 32'd0,        32'h12345678, 32'd0,        32'd0);

        // stall on read while busy; second start during busy is dropped
        old_hi = cur_hi;
        exp_hi_q.push_back(32'hFFFFFFFF);
        exp_lo_q.push_back(32'hFFFFFFE2);
        exp_cyc_q.push_back(cyc + 35);
        start = 1'b1; op = 3'b001; A = 32'd6; B = 32'hFFFFFFFB;
        step();
        start = 1'b0; op = 3'b111;
        step();
        step();
        rd_req = 1'b1; rd_sel = 1'b1;
        for (int k = 3; k <= 36; k++) begin
            if (k == 10) begin
                start = 1'b1; op = 3'b000; A = 32'd1; B = 32'd1;
            end else begin
                start = 1'b0; op = 3'b111;
            end
            @(negedge clk);
            check($sformatf("stall_k%0d", k), {31'b0, stall}, {31'b0, (k <= 35)});
            if (k < 35) check($sformatf("rd_old_k%0d", k), rd_data, old_hi);
            step();
        end
        rd_req = 1'b0;
        cur_hi = 32'hFFFFFFFF; cur_lo = 32'hFFFFFFE2;
        @(negedge clk);
        check("rd_new_hi", rd_data, 32'hFFFFFFFF);
        rd_sel = 1'b0;
        #1;
        check("rd_new_lo", rd_data, 32'hFFFFFFE2);
        step();

        // reset in the middle of RUN, then MTLO
        start = 1'b1; op = 3'b001; A = 32'd3; B = 32'd3;
        step();
        start = 1'b0; op = 3'b111;
        for (int k = 1; k < 20; k++) step();
        @(negedge clk);
        check("mid_busy", {31'b0, busy}, 32'd1);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("mrst_busy", {31'b0, busy}, 32'd0);
        check("mrst_hi", outHI, 32'd0);
        check("mrst_lo", outLO, 32'd0);
        step();
        start = 1'b1; op = 3'b101; A = 32'h00001234;
        step();
        start = 1'b0; op = 3'b111;
        @(negedge clk);
        check("mtlo2_lo", outLO, 32'h00001234);
        check("mtlo2_hi", outHI, 32'd0);
        check("mtlo2_busy", {31'b0, busy}, 32'd0);
        for (int k = 0; k < 40; k++) step();
        @(negedge clk);
        check("queue_empty", exp_hi_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
